// File: rtl/pmsm_ctrl_pkg.sv
// pmsm_ctrl_pkg: shared FSM state type, datapath widths and rotor wrap-window bounds.
package pmsm_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERR, S_PI, S_OUT} state_e;
    localparam int ERR_W = 13;
    localparam int P_W   = 21;
    localparam int INT_W = 24;
    localparam int SUM_W = 25;
    localparam logic [11:0] POS_LO = 12'd1024;
    localparam logic [11:0] POS_HI = 12'd3072;
endpackage

// File: rtl/pmsm_pi_core.sv
// pmsm_pi_core: PI arithmetic (error, proportional, integrator with clamp and anti-windup, output saturation).
// Ports: clk, rst (sync active-high); clr_i forces idle (zeroes integrator, output, flags);
// err_en_i / pi_en_i / out_en_i are the ERR / PI / OUT stage strobes; ref_i, speed_i latched operands;
// phase_o voltage command, cmd_valid_o one-cycle update pulse, sat_o last update clamped.
module pmsm_pi_core import pmsm_ctrl_pkg::*; #(
    parameter int KP         = 8,
    parameter int KI         = 1,
    parameter int GAIN_SHIFT = 4,
    parameter int INT_LIM    = (1 << 22) - 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        err_en_i,
    input  logic        pi_en_i,
    input  logic        out_en_i,
    input  logic [11:0] ref_i,
    input  logic [11:0] speed_i,
    output logic [11:0] phase_o,
    output logic        cmd_valid_o,
    output logic        sat_o
);
    localparam logic signed [SUM_W-1:0] LIM  = SUM_W'(INT_LIM);
    localparam logic signed [SUM_W-1:0] VMAX = SUM_W'(4095);
    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [P_W-1:0]   p_q, p_d;
    logic signed [INT_W-1:0] int_q, int_d;
    logic signed [SUM_W-1:0] cand, sum, s;
    logic [11:0] phase_q, phase_d;
    logic sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d, vld_q, hold;
    always_comb begin
        err_d    = $signed({1'b0, ref_i}) - $signed({1'b0, speed_i});
        p_d      = P_W'(err_q) * P_W'(KP);
        cand     = SUM_W'(int_q) + SUM_W'(err_q) * SUM_W'(KI);
        // Stop integrating further into a rail the output is already pinned against.
        hold     = (sat_hi_q && err_q > 0) || (sat_lo_q && err_q < 0);
        int_d    = hold ? int_q : cand > LIM ? INT_W'(LIM) : cand < -LIM ? INT_W'(-LIM) : INT_W'(cand);
        sum      = SUM_W'(p_q) + SUM_W'(int_q);
        s        = sum >>> GAIN_SHIFT;
        sat_hi_d = s > VMAX;
        sat_lo_d = s[SUM_W-1];
        phase_d  = sat_hi_d ? 12'hFFF : sat_lo_d ? 12'h000 : s[11:0];
    end
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            err_q    <= '0;
            p_q      <= '0;
            int_q    <= '0;
            phase_q  <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            if (err_en_i) err_q <= err_d;
            if (pi_en_i) begin
                p_q   <= p_d;
                int_q <= int_d;
            end
            if (out_en_i) begin
                phase_q  <= phase_d;
                sat_hi_q <= sat_hi_d;
                sat_lo_q <= sat_lo_d;
            end
            vld_q <= out_en_i;
        end
    end
    assign phase_o     = phase_q;
    assign cmd_valid_o = vld_q;
    assign sat_o       = sat_hi_q | sat_lo_q;
endmodule

// File: rtl/pmsm_speed_ctrl.sv
// pmsm_speed_ctrl: sampled PI speed loop driving the PMSM phase voltage, plus signed revolution counter.
// Ports: clk, rst (sync active-high); enable runs the loop; speed_ref setpoint; motor_speed measurement;
// rotor_position 0..4095 wrapping; phase_voltage command; cmd_valid update pulse; sat last update clamped;
// rev_count signed revolutions. Define PMSM_CTRL_RAMP_EN to slew the reference by RAMP_STEP per sample.
module pmsm_speed_ctrl import pmsm_ctrl_pkg::*; #(
    parameter int SAMPLE_DIV = 1000,
    parameter int KP         = 8,
    parameter int KI         = 1,
    parameter int GAIN_SHIFT = 4,
    parameter int INT_LIM    = (1 << 22) - 1
`ifdef PMSM_CTRL_RAMP_EN
    , parameter int RAMP_STEP = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] speed_ref,
    input  logic [11:0] motor_speed,
    input  logic [11:0] rotor_position,
    output logic [11:0] phase_voltage,
    output logic        cmd_valid,
    output logic        sat,
    output logic [15:0] rev_count
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0] ref_q, ref_d, spd_q, spd_d, ref_step, pos_q;
    logic [15:0] rev_q, rev_d;
    logic smp, err_en, pi_en, out_en, fwd, bwd;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            spd_q   <= '0;
            pos_q   <= '0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            spd_q   <= spd_d;
            pos_q   <= rotor_position;
            rev_q   <= rev_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_WAIT;
            S_WAIT:  state_d = smp ? S_ERR : S_WAIT;
            S_ERR:   state_d = S_PI;
            S_PI:    state_d = S_OUT;
            S_OUT:   state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
    end
    always_comb begin
        err_en = state_q == S_ERR;
        pi_en  = state_q == S_PI;
        out_en = state_q == S_OUT;
    end
    // Counter keeps running through ERR/PI/OUT so samples stay exactly SAMPLE_DIV apart.
    always_comb begin
        smp   = state_q == S_WAIT && cnt_q == CNT_MAX;
        cnt_d = (!enable || state_q == S_IDLE || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
`ifdef PMSM_CTRL_RAMP_EN
        ref_step = {1'b0, speed_ref} > {1'b0, ref_q} + 13'(RAMP_STEP) ? ref_q + 12'(RAMP_STEP) :
                   {1'b0, speed_ref} + 13'(RAMP_STEP) < {1'b0, ref_q} ? ref_q - 12'(RAMP_STEP) : speed_ref;
`else
        ref_step = speed_ref;
`endif
        ref_d = (!enable || state_q == S_IDLE) ? '0 : smp ? ref_step : ref_q;
        spd_d = smp ? motor_speed : spd_q;
    end
    always_comb begin
        fwd   = pos_q >= POS_HI && rotor_position < POS_LO;
        bwd   = pos_q < POS_LO && rotor_position >= POS_HI;
        rev_d = fwd ? rev_q + 16'd1 : bwd ? rev_q - 16'd1 : rev_q;
    end
    pmsm_pi_core #(
        .KP         (KP),
        .KI         (KI),
        .GAIN_SHIFT (GAIN_SHIFT),
        .INT_LIM    (INT_LIM)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (!enable),
        .err_en_i    (err_en),
        .pi_en_i     (pi_en),
        .out_en_i    (out_en),
        .ref_i       (ref_q),
        .speed_i     (spd_q),
        .phase_o     (phase_voltage),
        .cmd_valid_o (cmd_valid),
        .sat_o       (sat)
    );
    assign rev_count = rev_q;
endmodule

// File: tb/tb_pmsm_speed_ctrl.sv
// tb_pmsm_speed_ctrl: directed table-driven bench for pmsm_speed_ctrl with default parameters.
module tb_pmsm_speed_ctrl;
    localparam int DIV = 1000;
    logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic [11:0] speed_ref = '0, motor_speed = '0, rotor_position = '0, phase_voltage;
    logic cmd_valid, sat;
    logic [15:0] rev_count;
    int n_cmp = 0, n_fail = 0;
    typedef struct { logic [11:0] sref; logic [11:0] spd; logic [11:0] exp_v; logic exp_sat; } pi_vec_t;
    typedef struct { logic [11:0] pos; logic [15:0] exp_rev; } rev_vec_t;
    pi_vec_t  wv [12];
    rev_vec_t rv [12];
    pmsm_speed_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .speed_ref      (speed_ref),
        .motor_speed    (motor_speed),
        .rotor_position (rotor_position),
        .phase_voltage  (phase_voltage),
        .cmd_valid      (cmd_valid),
        .sat            (sat),
        .rev_count      (rev_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic wait_cmd(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_valid && n < lim);
    endtask
    initial begin
        int n, cnt;
        wv[0]  = '{12'd4095, 12'd0,    12'd2303, 1'b0};
        wv[1]  = '{12'd4095, 12'd0,    12'd2559, 1'b0};
        wv[2]  = '{12'd4095, 12'd0,    12'd2815, 1'b0};
        wv[3]  = '{12'd4095, 12'd0,    12'd3071, 1'b0};
        wv[4]  = '{12'd4095, 12'd0,    12'd3327, 1'b0};
        wv[5]  = '{12'd4095, 12'd0,    12'd3583, 1'b0};
        wv[6]  = '{12'd4095, 12'd0,    12'd3839, 1'b0};
        wv[7]  = '{12'd4095, 12'd0,    12'd4095, 1'b0};
        wv[8]  = '{12'd4095, 12'd0,    12'd4095, 1'b1};
        wv[9]  = '{12'd4095, 12'd0,    12'd4095, 1'b1};
        wv[10] = '{12'd0,    12'd4095, 12'd0,    1'b0};
        wv[11] = '{12'd4095, 12'd0,    12'd4095, 1'b1};
        rv[0]  = '{12'd2000, 16'd0};
        rv[1]  = '{12'd4000, 16'd0};
        rv[2]  = '{12'd5,    16'd1};
        rv[3]  = '{12'd4000, 16'd0};
        rv[4]  = '{12'd3072, 16'd0};
        rv[5]  = '{12'd1023, 16'd1};
        rv[6]  = '{12'd3072, 16'd0};
        rv[7]  = '{12'd3071, 16'd0};
        rv[8]  = '{12'd0,    16'd0};
        rv[9]  = '{12'd1024, 16'd0};
        rv[10] = '{12'd4095, 16'd0};
        rv[11] = '{12'd0,    16'd1};
        do_reset();
        chk("rst_phase", phase_voltage, 0);
        chk("rst_cmd", cmd_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_rev", rev_count, 0);
        for (int i = 0; i < 12; i++) begin
            rotor_position = rv[i].pos;
            @(negedge clk);
            chk($sformatf("rev[%0d]", i), rev_count, rv[i].exp_rev);
        end
        rotor_position = 12'd10;
        do_reset();
        @(negedge clk);
        chk("rev_10", rev_count, 0);
        rotor_position = 12'd4090;
        @(negedge clk);
        chk("rev_neg", rev_count, 16'hFFFF);
        do_reset();
        speed_ref = 12'd1000;
        motor_speed = 12'd0;
        enable = 1'b1;
        wait_cmd(2 * DIV, n);
        chk("step_lat", n, DIV + 4);
        chk("step_phase", phase_voltage, 562);
        chk("step_sat", sat, 0);
        wait_cmd(2 * DIV, n);
        chk("step2_period", n, DIV);
        chk("step2_phase", phase_voltage, 625);
        @(negedge clk);
        chk("cmd_pulse", cmd_valid, 0);
        repeat (DIV - 4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_phase", phase_voltage, 0);
        chk("abort_cmd", cmd_valid, 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(cmd_valid);
        end
        chk("abort_nocmd", cnt, 0);
        enable = 1'b1;
        wait_cmd(2 * DIV, n);
        chk("reen_lat", n, DIV + 4);
        chk("reen_phase", phase_voltage, 562);
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            speed_ref = wv[i].sref;
            motor_speed = wv[i].spd;
            wait_cmd(2 * DIV, n);
            chk($sformatf("wind_period[%0d]", i), n, i == 0 ? DIV + 4 : DIV);
            chk($sformatf("wind_phase[%0d]", i), phase_voltage, wv[i].exp_v);
            chk($sformatf("wind_sat[%0d]", i), sat, wv[i].exp_sat);
        end
        do_reset();
        chk("rst2_phase", phase_voltage, 0);
        chk("rst2_sat", sat, 0);
        speed_ref = 12'd0;
        motor_speed = 12'd500;
        enable = 1'b1;
        wait_cmd(2 * DIV, n);
        chk("neg_lat", n, DIV + 4);
        chk("neg_phase", phase_voltage, 0);
        chk("neg_sat", sat, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
